// File: rtl/adder_arbiter.sv
// Two-requester round-robin arbiter serialising W-bit additions through one shared 4-bit adder.
// Optional macro ADDER_ARBITER_CIN_SKIP_EN skips the carry-in step for nibbles whose carry-in is 0.
module adder_arbiter #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  input  logic                 req1_valid,
  output logic                 req0_ready,
  output logic                 req1_ready,
  input  logic [4*NIBBLES-1:0] req0_a,
  input  logic [4*NIBBLES-1:0] req0_b,
  input  logic [4*NIBBLES-1:0] req1_a,
  input  logic [4*NIBBLES-1:0] req1_b,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  input  logic [3:0]           add_s,
  input  logic                 add_c,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [4*NIBBLES-1:0] resp_sum,
  output logic                 resp_cout,
  output logic                 resp_id
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, CIN, ADDB, DONE} state_t;

  state_t          state, state_next;
  logic [W-1:0]    a_q, b_q, sum_q;
  logic [W-1:0]    sel_a, sel_b;
  logic [3:0]      partial_q;
  logic            c1_q, carry_q, id_q, last_grant_q;
  logic [IW-1:0]   idx_q, idx_inc;
  logic            accept, grant, last_nib, carry_next;

  // Ready is gated by rst_n so it drops the instant reset is asserted.
  assign req0_ready = rst_n && (state == IDLE) && req0_valid && (!req1_valid || last_grant_q);
  assign req1_ready = rst_n && (state == IDLE) && req1_valid && (!req0_valid || !last_grant_q);
  assign accept     = req0_ready || req1_ready;
  assign grant      = req1_ready;
  assign sel_a      = grant ? req1_a : req0_a;
  assign sel_b      = grant ? req1_b : req0_b;

  assign idx_inc    = idx_q + 1'b1;
  assign last_nib   = (idx_q == IW'(NIBBLES - 1));
  assign carry_next = c1_q | add_c;

  assign resp_valid = (state == DONE);
  assign resp_sum   = sum_q;
  assign resp_cout  = carry_q;
  assign resp_id    = id_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    add_a      = '0;
    add_b      = '0;
    unique case (state)
      IDLE: begin
        if (accept) begin
`ifdef ADDER_ARBITER_CIN_SKIP_EN
          state_next = ADDB;
`else
          state_next = CIN;
`endif
        end
      end
      CIN: begin
        add_a      = a_q[{idx_q, 2'b00} +: 4];
        add_b      = {3'b000, carry_q};
        state_next = ADDB;
      end
      ADDB: begin
        add_a = partial_q;
        add_b = b_q[{idx_q, 2'b00} +: 4];
        if (last_nib) begin
          state_next = DONE;
        end else begin
`ifdef ADDER_ARBITER_CIN_SKIP_EN
          state_next = carry_next ? CIN : ADDB;
`else
          state_next = CIN;
`endif
        end
      end
      DONE: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q          <= '0;
      b_q          <= '0;
      sum_q        <= '0;
      partial_q    <= '0;
      c1_q         <= 1'b0;
      carry_q      <= 1'b0;
      id_q         <= 1'b0;
      idx_q        <= '0;
      last_grant_q <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_q          <= sel_a;
            b_q          <= sel_b;
            id_q         <= grant;
            last_grant_q <= grant;
            carry_q      <= 1'b0;
            idx_q        <= '0;
            partial_q    <= sel_a[3:0];
            c1_q         <= 1'b0;
          end
        end
        CIN: begin
          partial_q <= add_s;
          c1_q      <= add_c;
        end
        ADDB: begin
          sum_q[{idx_q, 2'b00} +: 4] <= add_s;
          carry_q                    <= carry_next;
          if (!last_nib) begin
            idx_q <= idx_inc;
            // With skip, a direct ADDB->ADDB step needs the next A nibble preloaded as partial.
            partial_q <= a_q[{idx_inc, 2'b00} +: 4];
            c1_q      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed scenarios plus randomized transactions
// checked against an arithmetic reference model (sum, carry, round-robin grant, latency).
module tb_adder_arbiter;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]   add_a, add_b, add_s;
  logic         add_c;
  logic         resp_valid, resp_ready, resp_cout, resp_id;
  logic [W-1:0] resp_sum;

  int unsigned  total  = 0;
  int unsigned  passed = 0;
  logic         model_last;

  always #5 clk = ~clk;

  // Shared external 4-bit adder.
  assign {add_c, add_s} = {1'b0, add_a} + {1'b0, add_b};

  adder_arbiter #(.NIBBLES(NIB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .add_a(add_a), .add_b(add_b), .add_s(add_s), .add_c(add_c),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_sum(resp_sum), .resp_cout(resp_cout), .resp_id(resp_id)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int exp_latency(input logic [W-1:0] a, input logic [W-1:0] b);
    int k = 0;
`ifdef ADDER_ARBITER_CIN_SKIP_EN
    for (int i = 1; i < NIB; i++) begin
      longint unsigned m  = 64'd1 << (4 * i);
      longint unsigned lo = (longint'(a) % m) + (longint'(b) % m);
      if (lo >= m) k++;
    end
    return NIB + k;
`else
    return 2 * NIB + k;
`endif
  endfunction

  task automatic txn(input logic v0, input logic v1,
                     input logic [W-1:0] a0, input logic [W-1:0] b0,
                     input logic [W-1:0] a1, input logic [W-1:0] b1,
                     input logic hold, input int stall,
                     output int wait_cyc, output logic got_id);
    logic [W-1:0] ea, eb, snap;
    logic [W:0]   esum;
    logic         eid, sc;
    int           edges;
    req0_valid = v0; req1_valid = v1;
    req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
    #1;
    wait_cyc = 0;
    while (!(req0_ready || req1_ready) && wait_cyc < 40) begin
      @(posedge clk); #1; wait_cyc++;
    end
    check("ready_seen", 32'(req0_ready || req1_ready), 32'd1);
    check("ready_onehot", 32'(req0_ready && req1_ready), 32'd0);
    eid = (v0 && v1) ? ~model_last : v1;
    check("grant_id", 32'(req1_ready), 32'(eid));
    got_id     = req1_ready;
    model_last = eid;
    ea   = eid ? a1 : a0;
    eb   = eid ? b1 : b0;
    esum = {1'b0, ea} + {1'b0, eb};
    @(posedge clk); #1;
    req0_a = W'($urandom); req0_b = W'($urandom);
    req1_a = W'($urandom); req1_b = W'($urandom);
    if (!hold) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    edges = 0;
    sc    = 1'b0;
    while (!resp_valid && edges < 40) begin
      @(posedge clk); #1; edges++;
      if (req0_ready || req1_ready) sc = 1'b1;
    end
    check("busy_no_ready", 32'(sc), 32'd0);
    check("latency", 32'(edges), 32'(exp_latency(ea, eb)));
    check("sum", 32'(resp_sum), 32'(esum[W-1:0]));
    check("cout", 32'(resp_cout), 32'(esum[W]));
    check("resp_id", 32'(resp_id), 32'(eid));
    if (stall > 0) begin
      resp_ready = 1'b0;
      snap = resp_sum;
      sc   = 1'b0;
      repeat (stall) begin
        @(posedge clk); #1;
        if (!resp_valid || resp_sum !== snap || resp_cout !== esum[W] || resp_id !== eid ||
            req0_ready || req1_ready) sc = 1'b1;
      end
      check("stall_stable", 32'(sc), 32'd0);
      resp_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("resp_dropped", 32'(resp_valid), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_sum", 32'(resp_sum), 32'd0);
    check("rst_cout_id", 32'({resp_cout, resp_id}), 32'd0);
    check("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
    check("rst_add", 32'({add_a, add_b}), 32'd0);
    @(posedge clk); @(posedge clk); #3;
    rst_n      = 1'b1;
    model_last = 1'b1;
  endtask

  initial begin
    int       wc;
    logic     gid;
    logic     seen;
    logic     v0, v1;
    rst_n = 1'b0; resp_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    model_last = 1'b1;
    #22;
    do_reset();
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;

    // Carry rippling through every nibble.
    txn(1, 0, 16'h0001, 16'hFFFF, 16'h0, 16'h0, 0, 0, wc, gid);

    // Fresh reset: requester 0 wins first, then requester 1.
    do_reset();
    txn(1, 1, 16'h1234, 16'h1111, 16'h00FF, 16'h0001, 1, 0, wc, gid);
    check("first_grant", 32'(gid), 32'd0);
    txn(0, 1, 16'h1234, 16'h1111, 16'h00FF, 16'h0001, 0, 0, wc, gid);
    check("second_grant", 32'(gid), 32'd1);

    // Back-pressure with req1 waiting; req1 must be accepted right after the handshake.
    txn(1, 1, 16'hABCD, 16'h1357, 16'h4444, 16'h8888, 1, 5, wc, gid);
    txn(0, 1, 16'h0, 16'h0, 16'h4444, 16'h8888, 0, 0, wc, gid);
    check("post_stall_wait", 32'(wc), 32'd0);

    // Reset in the middle of nibble 2.
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_a = 16'hFFFF; req0_b = 16'h0001;
    #1;
    while (!req0_ready) begin @(posedge clk); #1; end
    @(posedge clk);
`ifdef ADDER_ARBITER_CIN_SKIP_EN
    repeat (4) @(posedge clk);
`else
    repeat (5) @(posedge clk);
`endif
    #2;
    do_reset();
    req0_valid = 1'b0;
    seen = 1'b0;
    repeat (12) begin @(posedge clk); #1; if (resp_valid) seen = 1'b1; end
    check("no_resp_after_rst", 32'(seen), 32'd0);
    txn(1, 0, 16'h0002, 16'h0003, 16'h0, 16'h0, 0, 0, wc, gid);

    // Continuous contention alternates 0,1,0,1.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      txn(1, 1, W'($urandom), W'($urandom), W'($urandom), W'($urandom), 1, 0, wc, gid);
      check("alternate", 32'(gid), 32'(i % 2));
    end

`ifdef ADDER_ARBITER_CIN_SKIP_EN
    txn(1, 0, 16'h000F, 16'h0001, 16'h0, 16'h0, 0, 0, wc, gid);
`endif

    for (int i = 0; i < 10; i++) begin
      v0 = 1'($urandom);
      v1 = 1'($urandom);
      if (!v0 && !v1) v0 = 1'b1;
      txn(v0, v1, W'($urandom), W'($urandom), W'($urandom), W'($urandom),
          1'($urandom), $urandom_range(0, 2), wc, gid);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
